debug_seq: RTL and testbench

Sequencing controller in front of the combinational debug multiplexer. It accepts one debug command at a time over a valid/ready handshake and drives the multiplexer's select, address, write-enable and write-data inputs cycle by cycle. For halt and step commands it polls the selected core's stopped flag until the core reports stopped or a timeout expires, then returns a single response over a second valid/ready handshake.

---
 rtl/debug_seq_if.sv | 32 +++
 rtl/debug_seq.sv | 199 +++++++++++++++++++
 tb/tb_debug_seq.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/debug_seq_if.sv
// Command, response and debug-multiplexer signals of the debug sequencer.
// The sequencer uses the slave modport. The requester/multiplexer side uses master.
interface debug_seq_if #(
  parameter int LOG_CORES  = 3,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [LOG_CORES-1:0]  cmd_core;
  logic [3:0]            cmd_reg;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic [LOG_CORES-1:0]  dbg_sel;
  logic [4:0]            dbg_addr;
  logic                  dbg_we;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic [DATA_WIDTH-1:0] dbg_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_core, cmd_reg, cmd_wdata, rsp_ready, dbg_rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, dbg_sel, dbg_addr, dbg_we, dbg_wdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_core, cmd_reg, cmd_wdata, rsp_ready, dbg_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, dbg_sel, dbg_addr, dbg_we, dbg_wdata
  );
endinterface

// File: rtl/debug_seq.sv
// Debug command sequencer: drives the debug multiplexer cycle by cycle and
// polls core stopped flags for halt/step/halt-all, returning one response per command.
module debug_seq #(
  parameter int         CORES      = 8,
  parameter int         LOG_CORES  = 3,
  parameter int         DATA_WIDTH = 16,
  parameter int         TIMEOUT    = 255,
  parameter int         TMO_WIDTH  = 8,
  parameter logic [1:0] MODE_STOP  = 2'b01,
  parameter logic [1:0] MODE_STEP  = 2'b10,
  parameter logic [1:0] MODE_RUN   = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  debug_seq_if.slave  bus
);
  localparam logic [2:0] OP_READ     = 3'b000;
  localparam logic [2:0] OP_WRITE    = 3'b001;
  localparam logic [2:0] OP_HALT     = 3'b010;
  localparam logic [2:0] OP_STEP     = 3'b011;
  localparam logic [2:0] OP_RESUME   = 3'b100;
  localparam logic [2:0] OP_HALT_ALL = 3'b101;
  localparam logic [4:0] ADDR_MODE   = 5'b10000;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_POLL, S_RESP} state_t;

  state_t                state_reg, state_next;
  logic [2:0]            op_reg, op_next;
  logic [TMO_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [CORES-1:0]      mask_reg, mask_next;
  logic                  cmd_ready_reg, cmd_ready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic [LOG_CORES-1:0]  dbg_sel_reg, dbg_sel_next;
  logic [4:0]            dbg_addr_reg, dbg_addr_next;
  logic                  dbg_we_reg, dbg_we_next;
  logic [DATA_WIDTH-1:0] dbg_wdata_reg, dbg_wdata_next;

  logic                  go_resp;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_err;
  logic [CORES-1:0]      mask_upd;

  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    cnt_next       = cnt_reg;
    mask_next      = mask_reg;
    cmd_ready_next = cmd_ready_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = rsp_err_reg;
    dbg_sel_next   = dbg_sel_reg;
    dbg_addr_next  = dbg_addr_reg;
    dbg_we_next    = dbg_we_reg;
    dbg_wdata_next = dbg_wdata_reg;
    go_resp        = 1'b0;
    resp_data      = '0;
    resp_err       = 1'b0;
    mask_upd       = mask_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_reg) begin
          op_next        = bus.cmd_op;
          dbg_sel_next   = bus.cmd_core;
          dbg_addr_next  = ADDR_MODE;
          dbg_we_next    = 1'b1;
          dbg_wdata_next = '0;
          cmd_ready_next = 1'b0;
          state_next     = S_ISSUE;
          unique case (bus.cmd_op)
            OP_READ: begin
              dbg_addr_next = {1'b0, bus.cmd_reg};
              dbg_we_next   = 1'b0;
            end
            OP_WRITE: begin
              dbg_addr_next  = {1'b0, bus.cmd_reg};
              dbg_wdata_next = bus.cmd_wdata;
            end
            OP_HALT:   dbg_wdata_next = DATA_WIDTH'(MODE_STOP);
            OP_STEP:   dbg_wdata_next = DATA_WIDTH'(MODE_STEP);
            OP_RESUME: dbg_wdata_next = DATA_WIDTH'(MODE_RUN);
            OP_HALT_ALL: begin
              dbg_sel_next   = '0;
              dbg_wdata_next = DATA_WIDTH'(MODE_STOP);
              mask_next      = '0;
            end
            default: begin
              go_resp  = 1'b1;
              resp_err = 1'b1;
            end
          endcase
        end
      end
      S_ISSUE: begin
        dbg_we_next    = 1'b0;
        dbg_wdata_next = '0;
        cnt_next       = '0;
        if (op_reg == OP_READ)
          state_next = S_CAPTURE;
        else if (op_reg == OP_WRITE || op_reg == OP_RESUME)
          go_resp = 1'b1;
        else
          state_next = S_POLL;
      end
      S_CAPTURE: begin
        go_resp   = 1'b1;
        resp_data = bus.dbg_rdata;
      end
      S_POLL: begin
        if (bus.dbg_rdata[0] || cnt_reg == TMO_WIDTH'(TIMEOUT - 1)) begin
          if (op_reg == OP_HALT_ALL) begin
            // A core that never reported stopped is flagged, and the sweep continues.
            if (!bus.dbg_rdata[0])
              mask_upd = mask_reg | (CORES'(1) << dbg_sel_reg);
            mask_next = mask_upd;
            if (dbg_sel_reg < LOG_CORES'(CORES - 1)) begin
              dbg_sel_next   = dbg_sel_reg + LOG_CORES'(1);
              dbg_we_next    = 1'b1;
              dbg_wdata_next = DATA_WIDTH'(MODE_STOP);
              state_next     = S_ISSUE;
            end else begin
              go_resp   = 1'b1;
              resp_data = DATA_WIDTH'(mask_upd);
              resp_err  = |mask_upd;
            end
          end else begin
            go_resp  = 1'b1;
            resp_err = !bus.dbg_rdata[0];
          end
        end else begin
          cnt_next = cnt_reg + TMO_WIDTH'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          rsp_data_next  = '0;
          rsp_err_next   = 1'b0;
          cmd_ready_next = 1'b1;
          state_next     = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (go_resp) begin
      state_next     = S_RESP;
      rsp_valid_next = 1'b1;
      rsp_data_next  = resp_data;
      rsp_err_next   = resp_err;
      dbg_sel_next   = '0;
      dbg_addr_next  = '0;
      dbg_we_next    = 1'b0;
      dbg_wdata_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      op_reg        <= '0;
      cnt_reg       <= '0;
      mask_reg      <= '0;
      cmd_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      dbg_sel_reg   <= '0;
      dbg_addr_reg  <= '0;
      dbg_we_reg    <= 1'b0;
      dbg_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      cnt_reg       <= cnt_next;
      mask_reg      <= mask_next;
      cmd_ready_reg <= cmd_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      dbg_sel_reg   <= dbg_sel_next;
      dbg_addr_reg  <= dbg_addr_next;
      dbg_we_reg    <= dbg_we_next;
      dbg_wdata_reg <= dbg_wdata_next;
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.dbg_sel   = dbg_sel_reg;
  assign bus.dbg_addr  = dbg_addr_reg;
  assign bus.dbg_we    = dbg_we_reg;
  assign bus.dbg_wdata = dbg_wdata_reg;
endmodule

// File: tb/tb_debug_seq.sv
// Directed bench for debug_seq: models the debug multiplexer read side and
// counts stop writes / poll cycles to check each command against hand-computed values.
module tb_debug_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debug_seq_if #(.LOG_CORES(3), .DATA_WIDTH(16)) bus ();

  debug_seq #(.CORES(8), .LOG_CORES(3), .DATA_WIDTH(16), .TIMEOUT(5), .TMO_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Multiplexer model: core 3 reg 5 reads BEEF; the stopped flag is set once
  // enough poll cycles have elapsed, except for cores in never_mask.
  logic [7:0] never_mask = 8'h00;
  int         stop_at    = 0;
  int         poll_cnt;
  int         we_cnt, poll_cycles;
  logic [7:0] stop_seen;
  logic [2:0] w_sel;
  logic [4:0] w_addr;
  logic [15:0] w_wdata;
  logic       clr_mon = 1'b1;

  assign bus.dbg_rdata = (bus.dbg_addr == 5'b00101 && bus.dbg_sel == 3'd3) ? 16'hBEEF :
                         (bus.dbg_addr == 5'b10000) ?
                           {15'd0, (!never_mask[bus.dbg_sel] && poll_cnt >= stop_at)} : 16'h0000;

  always @(posedge clk) begin
    if (clr_mon) begin
      we_cnt      <= 0;
      poll_cycles <= 0;
      poll_cnt    <= 0;
      stop_seen   <= 8'h00;
      w_sel       <= '0;
      w_addr      <= '0;
      w_wdata     <= '0;
    end else if (bus.dbg_we) begin
      we_cnt   <= we_cnt + 1;
      w_sel    <= bus.dbg_sel;
      w_addr   <= bus.dbg_addr;
      w_wdata  <= bus.dbg_wdata;
      poll_cnt <= 0;
      if (bus.dbg_addr == 5'b10000 && bus.dbg_wdata == 16'd1)
        stop_seen[bus.dbg_sel] <= 1'b1;
    end else if (bus.dbg_addr == 5'b10000) begin
      poll_cycles <= poll_cycles + 1;
      poll_cnt    <= poll_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    clr_mon = 1'b1;
    @(posedge clk); #1;
    clr_mon = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] core, input logic [3:0] rg,
                      input logic [15:0] wd);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_core  = core;
    bus.cmd_reg   = rg;
    bus.cmd_wdata = wd;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_wdata = 16'h0;
  endtask

  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) check({tag, "_rsp_timeout"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic take_rsp(input string tag);
    $display("txn %s: rsp_data=%04h rsp_err=%0d", tag, bus.rsp_data, bus.rsp_err);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, "_cmd_ready_after"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"},  32'(bus.rsp_data),  32'd0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    check({tag, "_dbg"}, {5'd0, bus.dbg_sel, bus.dbg_addr, bus.dbg_we, 2'b00, bus.dbg_wdata}, 32'd0);
  endtask

  task automatic do_read(input string tag);
    int lat;
    clear_mon();
    send(3'b000, 3'd3, 4'd5, 16'h0);
    wait_rsp(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_data"}, 32'(bus.rsp_data), 32'h0000BEEF);
    check({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_we_cnt"}, 32'(we_cnt), 32'd0);
    take_rsp(tag);
  endtask

  initial begin
    int lat;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_core  = 3'd0;
    bus.cmd_reg   = 4'd0;
    bus.cmd_wdata = 16'h0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("reset");

    // READ core 3 reg 5
    do_read("read");

    // WRITE core 2 reg 9
    clear_mon();
    send(3'b001, 3'd2, 4'd9, 16'h1234);
    wait_rsp("write", lat);
    check("write_we_cnt", 32'(we_cnt), 32'd1);
    check("write_bus", {11'd0, w_sel, w_addr, w_wdata}, {11'd0, 3'd2, 5'b01001, 16'h1234});
    check("write_err", 32'(bus.rsp_err), 32'd0);
    take_rsp("write");

    // HALT core 1, flag on the 4th sample
    never_mask = 8'h00;
    stop_at    = 3;
    clear_mon();
    send(3'b010, 3'd1, 4'd0, 16'h0);
    wait_rsp("halt", lat);
    check("halt_we_cnt", 32'(we_cnt), 32'd1);
    check("halt_write", {11'd0, w_sel, w_addr, w_wdata}, {11'd0, 3'd1, 5'b10000, 16'h0001});
    check("halt_polls", 32'(poll_cycles), 32'd4);
    check("halt_err", 32'(bus.rsp_err), 32'd0);
    take_rsp("halt");

    // STEP core 0, never stops: TIMEOUT=5 samples
    never_mask = 8'hFF;
    stop_at    = 0;
    clear_mon();
    send(3'b011, 3'd0, 4'd0, 16'h0);
    wait_rsp("step", lat);
    check("step_write", {11'd0, w_sel, w_addr, w_wdata}, {11'd0, 3'd0, 5'b10000, 16'h0002});
    check("step_polls", 32'(poll_cycles), 32'd5);
    check("step_err", 32'(bus.rsp_err), 32'd1);
    check("step_data", 32'(bus.rsp_data), 32'd0);
    take_rsp("step");

    // RESUME core 4
    clear_mon();
    send(3'b100, 3'd4, 4'd0, 16'h0);
    wait_rsp("resume", lat);
    check("resume_write", {11'd0, w_sel, w_addr, w_wdata}, {11'd0, 3'd4, 5'b10000, 16'h0003});
    check("resume_err", 32'(bus.rsp_err), 32'd0);
    take_rsp("resume");

    // HALT_ALL with cores 2 and 6 never stopping; then hold rsp_ready low
    never_mask = 8'h44;
    stop_at    = 0;
    clear_mon();
    send(3'b101, 3'd5, 4'd0, 16'h0);
    wait_rsp("halt_all", lat);
    check("halt_all_we_cnt", 32'(we_cnt), 32'd8);
    check("halt_all_stop_seen", 32'(stop_seen), 32'hFF);
    check("halt_all_polls", 32'(poll_cycles), 32'd16);
    check("halt_all_data", 32'(bus.rsp_data), 32'h0044);
    check("halt_all_err", 32'(bus.rsp_err), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_state", {12'd0, bus.cmd_ready, bus.rsp_valid, bus.rsp_err, 1'b0, bus.rsp_data},
            {12'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0044});
    end
    take_rsp("halt_all");

    // Reserved opcode
    clear_mon();
    send(3'b111, 3'd1, 4'd2, 16'hFFFF);
    wait_rsp("reserved", lat);
    check("reserved_err", 32'(bus.rsp_err), 32'd1);
    check("reserved_data", 32'(bus.rsp_data), 32'd0);
    check("reserved_we_cnt", 32'(we_cnt), 32'd0);
    take_rsp("reserved");

    // Reset during HALT_ALL polling
    never_mask = 8'hFF;
    clear_mon();
    send(3'b101, 3'd0, 4'd0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_poll_addr", 32'(bus.dbg_addr), 32'h10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("txn reset_mid_poll");
    check_reset_values("mid_reset");
    never_mask = 8'h00;
    do_read("read_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
